memory_strb_ws: RTL and testbench

//  Single-port parametrised memory with a valid/ready request handshake, per-byte

---
 rtl/memory_strb_ws.sv | 108 ++++++++++
 tb/tb_memory_strb_ws.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_strb_ws.sv
// rtl/memory_strb_ws.sv - single-port memory with byte strobes, wait states and range error
module memory_strb_ws #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_STATES = 0,
  parameter int STRB_WIDTH  = WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  valid_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o,
  output logic                  err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [WIDTH-1:0]      mem [0:DEPTH-1];
  logic                  in_range;

  // Only non-power-of-2 depths can see an address past the last word.
  always_comb begin
    in_range = (32'(addr_q) < 32'(DEPTH));
  end

  // Request FSM: latch on accept, count down wait states, perform one access, pulse ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          ready_o <= 1'b0;
          err_o   <= 1'b0;
          if (valid_i) begin
            addr_q  <= addr_i;
            wr_q    <= wr_rd_i;
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
            cnt     <= 4'(WAIT_STATES);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready_o <= 1'b1;
            state   <= S_RESP;
            if (in_range) begin
              err_o <= 1'b0;
              if (wr_q) begin
                for (int k = 0; k < STRB_WIDTH; k++) begin
                  if (wstrb_q[k]) begin
                    mem[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
                  end
                end
              end else begin
                rdata_o <= mem[addr_q];
              end
            end else begin
              // Out-of-range: writes are dropped, reads return zero.
              err_o <= 1'b1;
              if (!wr_q) begin
                rdata_o <= '0;
              end
            end
          end
        end
        S_RESP: begin
          ready_o <= 1'b0;
          err_o   <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          ready_o <= 1'b0;
          err_o   <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_strb_ws.sv
// tb/tb_memory_strb_ws.sv - directed self-checking bench for memory_strb_ws
module tb_memory_strb_ws;

  // Instance configurations: 0: WS=3, 1: WS=0, 2: WS=2, 3: WS=1 with DEPTH=20
  localparam int WS_T [4] = '{3, 0, 2, 1};
  localparam int DP_T [4] = '{32, 32, 32, 20};

  logic        clk;
  logic        rst;
  logic [4:0]  addr  [4];
  logic        wr_rd [4];
  logic [31:0] wdata [4];
  logic [3:0]  wstrb [4];
  logic        valid [4];
  logic [31:0] rdata [4];
  logic        ready [4];
  logic        err   [4];

  int vectors;
  int miscompares;
  logic [31:0] sb [32];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    memory_strb_ws #(
      .WIDTH      (32),
      .DEPTH      (DP_T[g]),
      .ADDR_WIDTH (5),
      .WAIT_STATES(WS_T[g])
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .addr_i (addr[g]),
      .wr_rd_i(wr_rd[g]),
      .wdata_i(wdata[g]),
      .wstrb_i(wstrb[g]),
      .valid_i(valid[g]),
      .rdata_o(rdata[g]),
      .ready_o(ready[g]),
      .err_o  (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on instance d; valid is left high (back-to-back style) until release_req.
  // If swap is set, addr is changed to a2 right after the accept edge.
  task automatic do_req(input int d, input logic wr, input logic [4:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input bit swap, input logic [4:0] a2,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    addr[d]  = a;
    wr_rd[d] = wr;
    wdata[d] = wd;
    wstrb[d] = st;
    valid[d] = 1'b1;
    @(posedge clk);
    #1;
    if (swap) addr[d] = a2;
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (ready[d] === 1'b1) break;
    end
    if (lat >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout inst=%0d addr=%0d: ready never seen", d, a);
    end
    rd = rdata[d];
    er = err[d];
    @(posedge clk);
    #1;
  endtask

  task automatic release_req(input int d);
    valid[d] = 1'b0;
  endtask

  task automatic test_reset;
    // Reset-state check on every instance
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (ready[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_state inst=%0d: got ready=%b err=%b rdata=%h, need 0/0/0",
                 d, ready[d], err[d], rdata[d]);
      end
    end
    // Reset asserted mid-WAIT of a write to addr 5 on the WS=3 instance
    @(negedge clk);
    addr[0] = 5'd5; wr_rd[0] = 1'b1; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF; valid[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midwait_ready: got %b, need 0", ready[0]);
    end
    valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held_ready: got %b, need 0", ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    begin
      logic [31:0] rd; logic er; int lat;
      do_req(0, 1'b0, 5'd5, 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
      release_req(0);
      vectors++;
      if (rd !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_no_partial_write: rdata=%h, need 00000000", rd);
      end
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat;
    do_req(1, 1'b1, 5'h15, 32'hDEAD_BEEF, 4'hF, 1'b0, 5'd0, rd, er, lat);
    vectors++;
    if (lat != 1 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_latency_err: lat=%0d err=%b, need 1/0", lat, er);
    end
    do_req(1, 1'b0, 5'h15, 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
    release_req(1);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 1) begin
      miscompares++;
      $display("FAIL rd_0x15: rdata=%h err=%b lat=%0d, need deadbeef/0/1", rd, er, lat);
    end
    // rdata must not be changed by a write
    do_req(1, 1'b1, 5'h3, 32'h0BAD_F00D, 4'hF, 1'b0, 5'd0, rd, er, lat);
    release_req(1);
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rdata_after_write: rdata=%h, need deadbeef", rd);
    end
  endtask

  task automatic test_strobes;
    logic [31:0] rd; logic er; int lat;
    do_req(1, 1'b1, 5'd7, 32'h1122_3344, 4'hF, 1'b0, 5'd0, rd, er, lat);
    do_req(1, 1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101, 1'b0, 5'd0, rd, er, lat);
    do_req(1, 1'b0, 5'd7, 32'h0, 4'hF, 1'b0, 5'd0, rd, er, lat);
    vectors++;
    if (rd !== 32'h11BB_33DD) begin
      miscompares++;
      $display("FAIL strobe_0101: rdata=%h, need 11bb33dd", rd);
    end
    do_req(1, 1'b1, 5'd7, 32'hFFFF_FFFF, 4'h0, 1'b0, 5'd0, rd, er, lat);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_zero_err: err=%b, need 0", er);
    end
    do_req(1, 1'b1, 5'd7, 32'hEEEE_EEEE, 4'b1010, 1'b0, 5'd0, rd, er, lat);
    do_req(1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
    release_req(1);
    vectors++;
    if (rd !== 32'hEEBB_EEDD) begin
      miscompares++;
      $display("FAIL strobe_1010: rdata=%h, need eebbeedd", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 32; i++) begin
      sb[i] = $urandom;
      do_req(2, 1'b1, 5'(i), sb[i], 4'hF, 1'b0, 5'd0, rd, er, lat);
      vectors++;
      if (lat != 3) begin
        miscompares++;
        $display("FAIL b2b_wr_latency addr=%0d: lat=%0d, need 3", i, lat);
      end
    end
    for (int i = 0; i < 32; i++) begin
      do_req(2, 1'b0, 5'(i), 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
      vectors++;
      if (rd !== sb[i] || er !== 1'b0 || lat != 3) begin
        miscompares++;
        $display("FAIL b2b_rd addr=%0d: rdata=%h err=%b lat=%0d, need %h/0/3", i, rd, er, lat, sb[i]);
      end
    end
    release_req(2);
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 20; i++) begin
      sb[i] = 32'hC0DE_0000 + 32'(i);
      do_req(3, 1'b1, 5'(i), sb[i], 4'hF, 1'b0, 5'd0, rd, er, lat);
    end
    do_req(3, 1'b0, 5'd19, 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
    vectors++;
    if (rd !== sb[19] || er !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_edge_rd19: rdata=%h err=%b, need %h/0", rd, er, sb[19]);
    end
    do_req(3, 1'b1, 5'd25, 32'h5A5A_5A5A, 4'hF, 1'b0, 5'd0, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || lat != 2) begin
      miscompares++;
      $display("FAIL oor_write: err=%b lat=%0d, need 1/2", er, lat);
    end
    do_req(3, 1'b0, 5'd25, 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin
      miscompares++;
      $display("FAIL oor_read: err=%b rdata=%h lat=%0d, need 1/00000000/2", er, rd, lat);
    end
    // err must drop once ready drops
    vectors++;
    if (err[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_err_after_resp: err=%b, need 0", err[3]);
    end
    for (int i = 0; i < 20; i++) begin
      do_req(3, 1'b0, 5'(i), 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
      vectors++;
      if (rd !== sb[i] || er !== 1'b0) begin
        miscompares++;
        $display("FAIL oor_unchanged addr=%0d: rdata=%h err=%b, need %h/0", i, rd, er, sb[i]);
      end
    end
    release_req(3);
  endtask

  task automatic test_idle_hold;
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1'b1, 5'd9, 32'h1234_5678, 4'hF, 1'b0, 5'd0, rd, er, lat);
    do_req(0, 1'b0, 5'd9, 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
    release_req(0);
    vectors++;
    if (rd !== 32'h1234_5678 || lat != 4) begin
      miscompares++;
      $display("FAIL hold_setup_rd9: rdata=%h lat=%0d, need 12345678/4", rd, lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (ready[0] !== 1'b0 || rdata[0] !== 32'h1234_5678) begin
        miscompares++;
        $display("FAIL idle_hold cycle=%0d: ready=%b rdata=%h, need 0/12345678", c, ready[0], rdata[0]);
      end
    end
    do_req(0, 1'b1, 5'd10, 32'h0000_000A, 4'hF, 1'b0, 5'd0, rd, er, lat);
    do_req(0, 1'b1, 5'd11, 32'h0000_000B, 4'hF, 1'b0, 5'd0, rd, er, lat);
    do_req(0, 1'b0, 5'd10, 32'h0, 4'h0, 1'b1, 5'd11, rd, er, lat);
    release_req(0);
    vectors++;
    if (rd !== 32'h0000_000A) begin
      miscompares++;
      $display("FAIL latched_addr_read: rdata=%h, need 0000000a", rd);
    end
    // write with address switched mid-WAIT must land on the latched address
    do_req(0, 1'b1, 5'd12, 32'h0000_00CC, 4'hF, 1'b1, 5'd13, rd, er, lat);
    do_req(0, 1'b0, 5'd13, 32'h0, 4'h0, 1'b0, 5'd0, rd, er, lat);
    release_req(0);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL latched_addr_write: addr13=%h, need 00000000", rd);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      addr[d] = '0; wr_rd[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0; valid[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_strobes();
    test_back_to_back();
    test_out_of_range();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
